chan_fifo_ctrl: RTL and testbench

//  Controller for an Argo channel FIFO. Wraps the external simple dual-port RAM: 1 write port, 1 read port, 1-cycle registered read.

---
 rtl/chan_fifo_ctrl.sv | 59 +++++
 tb/tb_chan_fifo_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo_ctrl.sv
// chan_fifo_ctrl: valid/ready channel FIFO over an external 1-cycle-read dual-port RAM with a 2-entry output skid
module chan_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_input_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_output_data
);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, mem_cnt;
  logic fetch_pend, push, pop, fetch;
  logic [1:0] occ, occ_a;
  logic [2:0] demand;
  logic [DATA_WIDTH-1:0] skid [2];
  always_comb begin
    mem_cnt = wr_ptr - rd_ptr;
    write_ready = !rst && (mem_cnt != FULL);
    push = write_valid && write_ready;
    read_valid = occ != 2'd0;
    pop = read_valid && read_ready;
    demand = {1'b0, occ} + {2'b0, fetch_pend} - {2'b0, pop};
    fetch = (mem_cnt != '0) && (demand < 3'd2);
    occ_a = occ - {1'b0, pop};
    count = {1'b0, mem_cnt} + {{(ADDR_WIDTH+1){1'b0}}, fetch_pend} + {{ADDR_WIDTH{1'b0}}, occ};
    read_data = skid[0];
    ram_write_en = push;
    ram_write_addr = wr_ptr[ADDR_WIDTH-1:0];
    ram_input_data = write_data;
    ram_read_addr = rd_ptr[ADDR_WIDTH-1:0];
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fetch_pend <= 1'b0;
      occ <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(push);
      rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(fetch);
      fetch_pend <= fetch;
      occ <= occ_a + {1'b0, fetch_pend};
      skid[0] <= (fetch_pend && occ_a == 2'd0) ? ram_output_data : pop ? skid[1] : skid[0];
      skid[1] <= (fetch_pend && occ_a != 2'd0) ? ram_output_data : skid[1];
    end
  end
endmodule

// File: tb/tb_chan_fifo_ctrl.sv
// tb_chan_fifo_ctrl: scoreboard bench for chan_fifo_ctrl at DEPTH=8 and DEPTH=4, each with its own RAM model
module tb_chan_fifo_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst;
  logic wv, wr, rv, rr, we;
  logic [31:0] wd, rd, ram_in, ram_out;
  logic [4:0] cnt;
  logic [2:0] waddr, raddr;
  logic [31:0] mem [8];
  logic wv4, wr4, rv4, rr4, we4;
  logic [31:0] wd4, rd4, ram_in4, ram_out4;
  logic [3:0] cnt4;
  logic [1:0] waddr4, raddr4;
  logic [31:0] mem4 [4];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] q [$];
  logic [31:0] q4 [$];
  logic [31:0] exp_w, exp_w4;

  chan_fifo_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clock(clock), .rst(rst), .write_valid(wv), .write_ready(wr), .write_data(wd),
    .read_valid(rv), .read_ready(rr), .read_data(rd), .count(cnt),
    .ram_write_en(we), .ram_write_addr(waddr), .ram_input_data(ram_in),
    .ram_read_addr(raddr), .ram_output_data(ram_out));

  chan_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut4 (
    .clock(clock), .rst(rst), .write_valid(wv4), .write_ready(wr4), .write_data(wd4),
    .read_valid(rv4), .read_ready(rr4), .read_data(rd4), .count(cnt4),
    .ram_write_en(we4), .ram_write_addr(waddr4), .ram_input_data(ram_in4),
    .ram_read_addr(raddr4), .ram_output_data(ram_out4));

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= ram_in;
    ram_out <= mem[raddr];
    if (we4) mem4[waddr4] <= ram_in4;
    ram_out4 <= mem4[raddr4];
  end

  always @(negedge clock) begin
    #2;
    if (rst) begin
      q.delete();
      q4.delete();
    end else begin
      if (wv && wr) q.push_back(wd);
      if (rv && rr) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL sb8_pop: got %h, required nothing (scoreboard empty)", rd);
        end else begin
          exp_w = q.pop_front();
          if (rd !== exp_w) begin
            mismatched++;
            $display("FAIL sb8_data: got %h, required %h", rd, exp_w);
          end
        end
      end
      if (wv4 && wr4) q4.push_back(wd4);
      if (rv4 && rr4) begin
        compared++;
        if (q4.size() == 0) begin
          mismatched++;
          $display("FAIL sb4_pop: got %h, required nothing (scoreboard empty)", rd4);
        end else begin
          exp_w4 = q4.pop_front();
          if (rd4 !== exp_w4) begin
            mismatched++;
            $display("FAIL sb4_data: got %h, required %h", rd4, exp_w4);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; wv = 1'b0; wd = '0; rr = 1'b0; wv4 = 1'b0; wd4 = '0; rr4 = 1'b0;
    @(negedge clock);
    wv = 1'b1;
    #1;
    compared++;
    if (wr !== 1'b0 || we !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_hold: write_ready=%b ram_write_en=%b, required 0 0", wr, we);
    end
    @(negedge clock);
    rst = 1'b0; wv = 1'b0;
    #1;
    compared++;
    if (rv !== 1'b0 || cnt !== 5'd0 || wr !== 1'b1 || rv4 !== 1'b0 || cnt4 !== 4'd0 || wr4 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state: rv=%b cnt=%0d wr=%b rv4=%b cnt4=%0d wr4=%b, required 0 0 1 0 0 1",
               rv, cnt, wr, rv4, cnt4, wr4);
    end
  endtask

  task automatic test_latency();
    @(negedge clock);
    wv = 1'b1; wd = 32'hA5; rr = 1'b1;
    #1;
    compared++;
    if (we !== 1'b1 || waddr !== 3'd0 || ram_in !== 32'hA5) begin
      mismatched++;
      $display("FAIL lat_write: we=%b addr=%0d data=%h, required 1 0 a5", we, waddr, ram_in);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      wv = 1'b0;
      #1;
      compared++;
      if (rv !== (i == 3) || cnt !== ((i < 4) ? 5'd1 : 5'd0)) begin
        mismatched++;
        $display("FAIL lat_cycle%0d: rv=%b cnt=%0d, required %b %0d", i, rv, cnt, i == 3, (i < 4) ? 1 : 0);
      end
      if (i == 3) begin
        compared++;
        if (rd !== 32'hA5) begin
          mismatched++;
          $display("FAIL lat_data: got %h, required a5", rd);
        end
      end
    end
  endtask

  task automatic test_fill();
    rr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      wv = 1'b1; wd = 32'(i);
      #1;
      compared++;
      if (wr !== 1'b1) begin
        mismatched++;
        $display("FAIL fill_ready%0d: write_ready=%b, required 1", i, wr);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wv = 1'b1; wd = 32'h99;
      #1;
      compared++;
      if (wr !== 1'b0 || we !== 1'b0 || cnt !== 5'd10) begin
        mismatched++;
        $display("FAIL fill_full: wr=%b we=%b cnt=%0d, required 0 0 10", wr, we, cnt);
      end
    end
    wv = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      rr = 1'b1;
      #1;
      compared++;
      if (rv !== 1'b1 || rd !== 32'(i)) begin
        mismatched++;
        $display("FAIL drain%0d: rv=%b data=%h, required 1 %h", i, rv, rd, 32'(i));
      end
    end
    @(negedge clock);
    #1;
    compared++;
    if (rv !== 1'b0 || cnt !== 5'd0 || wr !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_empty: rv=%b cnt=%0d wr=%b, required 0 0 1", rv, cnt, wr);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    for (int k = 0; k < 200 && got < 100; k++) begin
      @(negedge clock);
      wv = sent < 100; wd = 32'h1000 + 32'(sent); rr = 1'b1;
      #1;
      if (k >= 3 && sent < 100) begin
        compared++;
        if (rv !== 1'b1 || wr !== 1'b1 || cnt !== 5'd3) begin
          mismatched++;
          $display("FAIL b2b_cycle%0d: rv=%b wr=%b cnt=%0d, required 1 1 3", k, rv, wr, cnt);
        end
      end
      if (wv && wr) sent++;
      if (rv && rr) got++;
    end
    wv = 1'b0;
    compared++;
    if (got != 100) begin
      mismatched++;
      $display("FAIL b2b_total: got %0d words, required 100 within bound", got);
    end
  endtask

  task automatic test_random();
    int seen_max = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clock);
      wv4 = 1'($urandom_range(0, 1)); wd4 = $urandom; rr4 = 1'($urandom_range(0, 1));
      #1;
      compared++;
      if (cnt4 !== 4'(q4.size()) || cnt4 > 4'd6) begin
        mismatched++;
        $display("FAIL rand_count%0d: count=%0d, required %0d (max 6)", k, cnt4, q4.size());
      end
      if (int'(cnt4) > seen_max) seen_max = int'(cnt4);
    end
    wv4 = 1'b0; rr4 = 1'b1;
    for (int k = 0; k < 20 && cnt4 != 4'd0; k++) @(negedge clock);
    #3;
    compared++;
    if (cnt4 !== 4'd0 || q4.size() != 0) begin
      mismatched++;
      $display("FAIL rand_drain: count=%0d left=%0d, required 0 0", cnt4, q4.size());
    end
    compared++;
    if (seen_max != 6) begin
      mismatched++;
      $display("FAIL rand_peak: peak count %0d, required 6 reached", seen_max);
    end
  endtask

  task automatic test_rst_mid();
    rr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      wv = 1'b1; wd = 32'h500 + 32'(i);
    end
    @(negedge clock);
    wv = 1'b0;
    @(negedge clock);
    #1;
    compared++;
    if (cnt !== 5'd5) begin
      mismatched++;
      $display("FAIL mid_held: count=%0d, required 5", cnt);
    end
    @(negedge clock);
    rst = 1'b1; wv = 1'b1; wd = 32'hDEAD;
    #1;
    compared++;
    if (wr !== 1'b0 || we !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_rst: wr=%b we=%b, required 0 0", wr, we);
    end
    @(negedge clock);
    rst = 1'b0; wv = 1'b0;
    #1;
    compared++;
    if (rv !== 1'b0 || cnt !== 5'd0 || wr !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_after: rv=%b cnt=%0d wr=%b, required 0 0 1", rv, cnt, wr);
    end
    @(negedge clock);
    wv = 1'b1; wd = 32'h77; rr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      wv = 1'b0;
      #1;
      compared++;
      if (rv !== (i == 3) || (i == 3 && rd !== 32'h77)) begin
        mismatched++;
        $display("FAIL mid_new%0d: rv=%b data=%h, required %b 77", i, rv, rd, i == 3);
      end
    end
    @(negedge clock);
    #1;
    compared++;
    if (rv !== 1'b0 || cnt !== 5'd0) begin
      mismatched++;
      $display("FAIL mid_stale: rv=%b cnt=%0d, required 0 0", rv, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    test_rst_mid();
    @(negedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
